// File: rtl/fft8_butterfly.sv
// Pipelined radix-2 DIT butterfly for the 8-point FFT: out1 = a + W8^k*b, out2 = a - W8^k*b.
// Three register stages (capture/twiddle, products, combine) plus a butterfly counter for stage/transform completion.
module fft8_butterfly #(
    parameter int DW = 24,
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [1:0]    tw_idx,
    input  logic [2:0]    addr_a,
    input  logic [2:0]    addr_b,
    input  logic [DW-1:0] a_re,
    input  logic [DW-1:0] a_im,
    input  logic [DW-1:0] b_re,
    input  logic [DW-1:0] b_im,
    output logic          out_valid,
    output logic [2:0]    out_addr1,
    output logic [2:0]    out_addr2,
    output logic [DW-1:0] out_re1,
    output logic [DW-1:0] out_im1,
    output logic [DW-1:0] out_re2,
    output logic [DW-1:0] out_im2,
    output logic          stage_done,
    output logic          fft_done,
    output logic          busy
);

    localparam int PW = DW + TW;
    localparam int SW = DW + TW + 1;

    function automatic logic signed [TW-1:0] tw_re(input logic [1:0] k);
        case (k)
            2'd0:    return TW'(16384);
            2'd1:    return TW'(11585);
            2'd2:    return TW'(0);
            default: return TW'(-11585);
        endcase
    endfunction

    function automatic logic signed [TW-1:0] tw_im(input logic [1:0] k);
        case (k)
            2'd0:    return TW'(0);
            2'd1:    return TW'(-11585);
            2'd2:    return TW'(-16384);
            default: return TW'(-11585);
        endcase
    endfunction

    // Q1.14 product back to DW bits: add half an LSB, arithmetic shift (round half up), wrap.
    function automatic logic signed [DW-1:0] round_q14(input logic signed [SW-1:0] p);
        return DW'((p + SW'(8192)) >>> 14);
    endfunction

    logic                 vld_p0, vld_p1, vld_p2;
    logic [2:0]           addr_a_p0, addr_b_p0, addr_a_p1, addr_b_p1;
    logic signed [DW-1:0] a_re_p0, a_im_p0, b_re_p0, b_im_p0;
    logic signed [TW-1:0] wr_p0, wi_p0;
    logic signed [DW-1:0] a_re_p1, a_im_p1;
    logic signed [PW-1:0] prr_p1, pii_p1, pri_p1, pir_p1;
    logic signed [SW-1:0] p_re, p_im;
    logic signed [DW-1:0] t_re, t_im;
    logic [3:0]           bfly_cnt, cnt_inc;

    // S1: operand capture and twiddle lookup
    always_ff @(posedge clk) begin
        a_re_p0   <= signed'(a_re);
        a_im_p0   <= signed'(a_im);
        b_re_p0   <= signed'(b_re);
        b_im_p0   <= signed'(b_im);
        wr_p0     <= tw_re(tw_idx);
        wi_p0     <= tw_im(tw_idx);
        addr_a_p0 <= addr_a;
        addr_b_p0 <= addr_b;
    end

    // S2: four partial products
    always_ff @(posedge clk) begin
        prr_p1    <= PW'(b_re_p0) * PW'(wr_p0);
        pii_p1    <= PW'(b_im_p0) * PW'(wi_p0);
        pri_p1    <= PW'(b_re_p0) * PW'(wi_p0);
        pir_p1    <= PW'(b_im_p0) * PW'(wr_p0);
        a_re_p1   <= a_re_p0;
        a_im_p1   <= a_im_p0;
        addr_a_p1 <= addr_a_p0;
        addr_b_p1 <= addr_b_p0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= in_valid;
            vld_p1 <= vld_p0;
        end
    end

    // S3: combine, round, add/subtract; outputs hold when no pair completes
    always_comb begin
        p_re    = SW'(prr_p1) - SW'(pii_p1);
        p_im    = SW'(pri_p1) + SW'(pir_p1);
        t_re    = round_q14(p_re);
        t_im    = round_q14(p_im);
        cnt_inc = bfly_cnt + 4'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p2     <= 1'b0;
            stage_done <= 1'b0;
            fft_done   <= 1'b0;
            bfly_cnt   <= 4'd0;
            out_addr1  <= 3'd0;
            out_addr2  <= 3'd0;
            out_re1    <= '0;
            out_im1    <= '0;
            out_re2    <= '0;
            out_im2    <= '0;
        end else begin
            vld_p2     <= vld_p1;
            stage_done <= vld_p1 && (cnt_inc[1:0] == 2'd0);
            fft_done   <= vld_p1 && (cnt_inc == 4'd12);
            if (vld_p1) begin
                bfly_cnt  <= (cnt_inc == 4'd12) ? 4'd0 : cnt_inc;
                out_addr1 <= addr_a_p1;
                out_addr2 <= addr_b_p1;
                out_re1   <= a_re_p1 + t_re;
                out_im1   <= a_im_p1 + t_im;
                out_re2   <= a_re_p1 - t_re;
                out_im2   <= a_im_p1 - t_im;
            end
        end
    end

    assign out_valid = vld_p2;
    assign busy      = vld_p0 | vld_p1 | vld_p2;

endmodule

// File: tb/tb_fft8_butterfly.sv
// Bench for fft8_butterfly: directed vector table, reset/throughput sequences and a randomized run
// checked against an arithmetic reference of the butterfly and its completion counter.
module tb_fft8_butterfly;

    localparam int DW = 24;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [1:0]    tw_idx = '0;
    logic [2:0]    addr_a = '0, addr_b = '0;
    logic [DW-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
    logic          out_valid, stage_done, fft_done, busy;
    logic [2:0]    out_addr1, out_addr2;
    logic [DW-1:0] out_re1, out_im1, out_re2, out_im2;

    fft8_butterfly #(.DW(DW), .TW(TW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .tw_idx(tw_idx),
        .addr_a(addr_a), .addr_b(addr_b),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .out_valid(out_valid), .out_addr1(out_addr1), .out_addr2(out_addr2),
        .out_re1(out_re1), .out_im1(out_im1), .out_re2(out_re2), .out_im2(out_im2),
        .stage_done(stage_done), .fft_done(fft_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [2:0] a1, a2;
        longint     r1, i1, r2, i2;
    } exp_t;

    typedef struct {
        int         k;
        logic [2:0] aa, ab;
        longint     ar, ai, br, bi;
        longint     o1r, o1i, o2r, o2i;
    } vec_t;

    int     n_cmp = 0;
    int     n_bad = 0;
    exp_t   pipe[3];
    exp_t   held;
    int     cnt_m = 0;
    int     dut_ov = 0, dut_sd = 0, dut_fd = 0;
    vec_t   tbl[4];
    longint twr[4] = '{16384, 11585, 0, -11585};
    longint twi[4] = '{0, -11585, -16384, -11585};

    function automatic longint wrapd(input longint x);
        longint m, h;
        m = longint'(1) << DW;
        h = m / 2;
        return ((x + h) % m + m) % m - h;
    endfunction

    function automatic longint sx(input logic [DW-1:0] x);
        return longint'(signed'(x));
    endfunction

    // Reference butterfly in plain integer arithmetic.
    function automatic exp_t ref_bfly(input int k, input logic [2:0] aa, input logic [2:0] ab,
                                      input longint ar, input longint ai,
                                      input longint br, input longint bi);
        exp_t   e;
        longint pr, pim, tr, ti;
        pr  = br * twr[k] - bi * twi[k];
        pim = br * twi[k] + bi * twr[k];
        tr  = wrapd((pr + 8192) >>> 14);
        ti  = wrapd((pim + 8192) >>> 14);
        e.v  = 1'b1;
        e.a1 = aa;
        e.a2 = ab;
        e.r1 = wrapd(ar + tr);
        e.i1 = wrapd(ai + ti);
        e.r2 = wrapd(ar - tr);
        e.i2 = wrapd(ai - ti);
        return e;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 3; i++) pipe[i] = '{1'b0, 3'd0, 3'd0, 0, 0, 0, 0};
        held  = '{1'b0, 3'd0, 3'd0, 0, 0, 0, 0};
        cnt_m = 0;
    endtask

    task automatic sample_check();
        exp_t e;
        logic sd, fd;
        e  = pipe[2];
        sd = 1'b0;
        fd = 1'b0;
        if (e.v) begin
            cnt_m++;
            sd = (cnt_m % 4 == 0);
            fd = (cnt_m == 12);
            if (fd) cnt_m = 0;
            held = e;
        end
        if (out_valid)  dut_ov++;
        if (stage_done) dut_sd++;
        if (fft_done)   dut_fd++;
        chk("out_valid", longint'(out_valid), longint'(e.v));
        chk("busy", longint'(busy), longint'(pipe[0].v | pipe[1].v | pipe[2].v));
        chk("stage_done", longint'(stage_done), longint'(sd));
        chk("fft_done", longint'(fft_done), longint'(fd));
        chk("out_addr1", longint'(out_addr1), longint'(held.a1));
        chk("out_addr2", longint'(out_addr2), longint'(held.a2));
        chk("out_re1", sx(out_re1), held.r1);
        chk("out_im1", sx(out_im1), held.i1);
        chk("out_re2", sx(out_re2), held.r2);
        chk("out_im2", sx(out_im2), held.i2);
    endtask

    // Drive one cycle of input, advance the model one edge and check at the following negedge.
    task automatic cycle(input logic v, input int k, input logic [2:0] aa, input logic [2:0] ab,
                         input longint ar, input longint ai, input longint br, input longint bi);
        longint tmp;
        in_valid = v;
        tw_idx   = k[1:0];
        addr_a   = aa;
        addr_b   = ab;
        tmp = ar; a_re = tmp[DW-1:0];
        tmp = ai; a_im = tmp[DW-1:0];
        tmp = br; b_re = tmp[DW-1:0];
        tmp = bi; b_im = tmp[DW-1:0];
        @(posedge clk);
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = ref_bfly(k, aa, ab, ar, ai, br, bi);
        pipe[0].v = v;
        @(negedge clk);
        sample_check();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 3'd0, 3'd0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        clear_model();
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_stage_done", longint'(stage_done), 0);
        chk("rst_fft_done", longint'(fft_done), 0);
        chk("rst_addrs", longint'({out_addr1, out_addr2}), 0);
        chk("rst_data", longint'({out_re1, out_im1}), 0);
        chk("rst_data2", longint'({out_re2, out_im2}), 0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold_valid", longint'(out_valid), 0);
        rst = 1'b1;
    endtask

    initial begin
        tbl[0] = '{0, 3'd0, 3'd4, 100, 0, 50, 0,     150, 0, 50, 0};
        tbl[1] = '{2, 3'd1, 3'd5, 0, 0, 1000, 200,   200, -1000, -200, 1000};
        tbl[2] = '{1, 3'd2, 3'd6, 0, 0, 16384, 0,    11585, -11585, -11585, 11585};
        tbl[3] = '{0, 3'd3, 3'd7, 8388607, 0, 1, 0,  -8388608, 0, 8388606, 0};

        clear_model();
        @(negedge clk);
        do_reset();
        idle(2);

        // Directed vectors: each pair alone, result checked 3 edges later against the table.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, tbl[i].k, tbl[i].aa, tbl[i].ab, tbl[i].ar, tbl[i].ai, tbl[i].br, tbl[i].bi);
            idle(2);
            chk("tbl_valid", longint'(out_valid), 1);
            chk("tbl_addr1", longint'(out_addr1), longint'(tbl[i].aa));
            chk("tbl_addr2", longint'(out_addr2), longint'(tbl[i].ab));
            chk("tbl_re1", sx(out_re1), tbl[i].o1r);
            chk("tbl_im1", sx(out_im1), tbl[i].o1i);
            chk("tbl_re2", sx(out_re2), tbl[i].o2r);
            chk("tbl_im2", sx(out_im2), tbl[i].o2i);
            idle(1);
        end

        // Twelve back-to-back pairs of one transform.
        do_reset();
        dut_ov = 0; dut_sd = 0; dut_fd = 0;
        for (int i = 0; i < 12; i++)
            cycle(1'b1, i % 4, 3'(i), 3'(i + 4), 1000, 0, 1000, 0);
        chk("busy_after_last_in", longint'(busy), 1);
        idle(2);
        chk("busy_last_out", longint'(busy), 1);
        idle(1);
        chk("busy_fallen", longint'(busy), 0);
        idle(2);
        chk("burst_out_valid_count", dut_ov, 12);
        chk("burst_stage_done_count", dut_sd, 3);
        chk("burst_fft_done_count", dut_fd, 1);

        // Reset with pairs in flight: nothing may emerge afterwards and counting restarts.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1, 3'(i), 3'(7 - i), 300 * i, -20, 4000, 777);
        do_reset();
        dut_ov = 0;
        idle(5);
        chk("flushed_no_output", dut_ov, 0);
        dut_sd = 0;
        for (int i = 0; i < 4; i++) cycle(1'b1, 3, 3'(i), 3'(i), 5, 6, 7, 8);
        idle(3);
        chk("restart_stage_done", dut_sd, 1);

        // Randomized traffic including full-scale operands.
        for (int n = 0; n < 400; n++) begin
            longint v[4];
            for (int j = 0; j < 4; j++) begin
                case ($urandom_range(0, 7))
                    0:       v[j] = 8388607;
                    1:       v[j] = -8388608;
                    default: v[j] = wrapd(longint'($urandom));
                endcase
            end
            cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), v[0], v[1], v[2], v[3]);
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
